ftoi_pipe: RTL and testbench

//   Parametrised, pipelined FP32 -> integer converter (fcvt.w/wu.s class) for the FPU.

---
 rtl/ftoi_pipe.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ftoi_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_pipe.sv
// ftoi_pipe -- pipelined IEEE-754 binary32 -> integer converter (fcvt.w/wu.s class).
//
// Two register stages with valid/ready flow control:
//   stage 1 : unpack, align {1,m} by (e-127), extract guard/sticky, classify
//   stage 2 : round per rm, negate, range-check / saturate, flags
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_x                binary32 operand
//   in_rm               rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RTZ)
//   in_sgn              1 = signed result, 0 = unsigned
//   in_tag              opaque tag, passed through
//   out_valid/out_ready result handshake
//   out_y, out_tag      integer result and its tag
//   out_nv, out_nx      invalid / inexact flags
//
// Build option
//   FTOI_FLAGS_EN  defined: out_nv/out_nx registered with out_y.
//                  undefined: out_nv/out_nx tied 0 (saturation still applied).
module ftoi_pipe #(
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [2:0]       in_rm,
   input  logic             in_sgn,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_nv,
   output logic             out_nx
);

   // Magnitude carries one bit beyond OUT_W so 2^OUT_W (unsigned overflow) is
   // still representable; rounding may add one more carry bit.
   localparam int MW = OUT_W + 1;
   localparam int RW = OUT_W + 2;
   localparam int WW = MW + 24;
   localparam logic signed [9:0] BIG_E = 10'(OUT_W + 1);
   localparam logic [RW-1:0]    HALF  = {{(RW-1){1'b0}}, 1'b1} << (OUT_W - 1);
   localparam logic [OUT_W-1:0] SMAX  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SMIN  = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] UMAX  = {OUT_W{1'b1}};

   logic s2_load, s1_adv;

   // ---------------- stage 1: unpack / align ----------------
   logic             s1_valid_q, s1_valid_d;
   logic             s1_sign_q, s1_sign_d;
   logic [MW-1:0]    s1_mag_q, s1_mag_d;
   logic             s1_g_q, s1_g_d, s1_s_q, s1_s_d;
   logic             s1_nan_q, s1_nan_d, s1_big_q, s1_big_d;
   logic [2:0]       s1_rm_q, s1_rm_d;
   logic             s1_sgn_q, s1_sgn_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic [7:0]        exp_x;
   logic [23:0]       mant24;
   logic signed [9:0] exp_s;
   logic [5:0]        sh_r;
   logic [6:0]        sh_l;
   logic [47:0]       frac_sh;
   logic [MW-1:0]     u_mag;
   logic              u_g, u_s, u_nan, u_big;

   assign exp_x  = in_x[30:23];
   assign mant24 = {1'b1, in_x[22:0]};
   assign exp_s  = $signed({2'b00, exp_x}) - 10'sd127;

   always_comb begin
      u_mag   = '0;
      u_g     = 1'b0;
      u_s     = 1'b0;
      u_nan   = 1'b0;
      u_big   = 1'b0;
      sh_r    = '0;
      sh_l    = '0;
      frac_sh = '0;
      if (exp_x == 8'hFF) begin
         u_nan = |in_x[22:0];
         u_big = ~|in_x[22:0];
      end else if (exp_x == 8'h00) begin
         u_s = |in_x[22:0];                // zero / subnormal: |x| < 0.5
      end else if (exp_s < -10'sd1) begin
         u_s = 1'b1;                       // 0 < |x| < 0.5: sticky only
      end else if (exp_s >= BIG_E) begin
         u_big = 1'b1;                     // caught before any shift can wrap
      end else if (exp_s <= 10'sd23) begin
         // Fraction bits land in [23:0]: guard at 23, sticky below.
         sh_r    = 6'(10'sd23 - exp_s);
         frac_sh = {mant24, 24'b0} >> sh_r;
         u_mag   = MW'(frac_sh[47:24]);
         u_g     = frac_sh[23];
         u_s     = |frac_sh[22:0];
      end else begin
         sh_l  = 7'(exp_s - 10'sd23);
         u_mag = MW'(WW'(mant24) << sh_l);
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_mag_d   = s1_mag_q;
      s1_g_d     = s1_g_q;
      s1_s_d     = s1_s_q;
      s1_nan_d   = s1_nan_q;
      s1_big_d   = s1_big_q;
      s1_rm_d    = s1_rm_q;
      s1_sgn_d   = s1_sgn_q;
      s1_tag_d   = s1_tag_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_sign_d = in_x[31];
            s1_mag_d  = u_mag;
            s1_g_d    = u_g;
            s1_s_d    = u_s;
            s1_nan_d  = u_nan;
            s1_big_d  = u_big;
            s1_rm_d   = in_rm;
            s1_sgn_d  = in_sgn;
            s1_tag_d  = in_tag;
         end
      end
   end

   // ---------------- stage 2: round / saturate ----------------
   logic             up;
   logic [RW-1:0]    rmag;
   logic [OUT_W-1:0] mag_o;
   logic [OUT_W-1:0] r_y;
   logic             r_nv, r_nx;

   always_comb begin
      up = 1'b0;
      case (s1_rm_q)
         3'd0:    up = s1_g_q & (s1_s_q | s1_mag_q[0]);
         3'd2:    up = s1_sign_q & (s1_g_q | s1_s_q);
         3'd3:    up = ~s1_sign_q & (s1_g_q | s1_s_q);
         3'd4:    up = s1_g_q;
         default: up = 1'b0;
      endcase
      rmag  = {1'b0, s1_mag_q} + {{(RW-1){1'b0}}, up};
      mag_o = rmag[OUT_W-1:0];
      r_y   = s1_sign_q ? -mag_o : mag_o;
      r_nv  = 1'b0;
      r_nx  = s1_g_q | s1_s_q;
      if (s1_nan_q) begin
         r_y  = s1_sgn_q ? SMAX : UMAX;
         r_nv = 1'b1;
      end else if (s1_big_q) begin
         r_y  = s1_sign_q ? (s1_sgn_q ? SMIN : '0) : (s1_sgn_q ? SMAX : UMAX);
         r_nv = 1'b1;
      end else if (!s1_sign_q) begin
         if (s1_sgn_q ? (rmag >= HALF) : (|rmag[RW-1:OUT_W])) begin
            r_y  = s1_sgn_q ? SMAX : UMAX;
            r_nv = 1'b1;
         end
      end else if (s1_sgn_q) begin
         if (rmag > HALF) begin
            r_y  = SMIN;
            r_nv = 1'b1;
         end
      end else if (rmag != '0) begin
         // unsigned, negative operand that rounds to -1 or below
         r_y  = '0;
         r_nv = 1'b1;
      end
      if (r_nv) r_nx = 1'b0;
   end

   assign s2_load  = !out_valid || out_ready;
   assign s1_adv   = !s1_valid_q || s2_load;
   assign in_ready = s1_adv;

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_y_q, out_y_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;

   always_comb begin
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_tag_d   = out_tag_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_y_d   = r_y;
            out_tag_d = s1_tag_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mag_q    <= '0;
         s1_g_q      <= 1'b0;
         s1_s_q      <= 1'b0;
         s1_nan_q    <= 1'b0;
         s1_big_q    <= 1'b0;
         s1_rm_q     <= '0;
         s1_sgn_q    <= 1'b0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_tag_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_mag_q    <= s1_mag_d;
         s1_g_q      <= s1_g_d;
         s1_s_q      <= s1_s_d;
         s1_nan_q    <= s1_nan_d;
         s1_big_q    <= s1_big_d;
         s1_rm_q     <= s1_rm_d;
         s1_sgn_q    <= s1_sgn_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_tag   = out_tag_q;

`ifdef FTOI_FLAGS_EN
   logic out_nv_q, out_nv_d, out_nx_q, out_nx_d;

   always_comb begin
      out_nv_d = out_nv_q;
      out_nx_d = out_nx_q;
      if (s2_load && s1_valid_q) begin
         out_nv_d = r_nv;
         out_nx_d = r_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_nv_q <= 1'b0;
         out_nx_q <= 1'b0;
      end else begin
         out_nv_q <= out_nv_d;
         out_nx_q <= out_nx_d;
      end
   end

   assign out_nv = out_nv_q;
   assign out_nx = out_nx_q;
`else
   // Flag terms have no load here; synthesis trims them.
   logic unused_flags;
   assign unused_flags = r_nv ^ r_nx;
   assign out_nv = 1'b0;
   assign out_nx = 1'b0;
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe -- bench for ftoi_pipe (OUT_W=32): table of conversions with
// scoreboard checking, random back-pressure pass, stall and reset sequences.
module tb_ftoi_pipe;
   localparam int OUT_W = 32;
   localparam int TAG_W = 5;
`ifdef FTOI_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready;
   logic [31:0]      in_x;
   logic [2:0]       in_rm;
   logic             in_sgn;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid, out_ready;
   logic [OUT_W-1:0] out_y;
   logic [TAG_W-1:0] out_tag;
   logic             out_nv, out_nx;

   ftoi_pipe #(.OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_rm(in_rm),
      .in_sgn(in_sgn), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_tag(out_tag), .out_nv(out_nv), .out_nx(out_nx));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [2:0]  rm;
      logic        sgn;
      logic [31:0] y;
      logic        nv;
      logic        nx;
   } vec_t;

   typedef struct {
      logic [31:0]      y;
      logic [TAG_W-1:0] tag;
      logic             nv;
      logic             nx;
   } exp_t;

   vec_t tv[$];
   exp_t sb[$];
   exp_t cur_exp;
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   rand_bp = 1'b0;

   // Scoreboard: push on input handshake, pop/compare on output handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_out: got y=%h tag=%0d, required no output", out_y, out_tag);
            end else begin
               mon_e = sb.pop_front();
               if (out_y !== mon_e.y || out_tag !== mon_e.tag ||
                   out_nv !== mon_e.nv || out_nx !== mon_e.nx) begin
                  n_bad++;
                  $display("FAIL result tag=%0d: got y=%h nv=%b nx=%b tag=%0d, required y=%h nv=%b nx=%b tag=%0d",
                           mon_e.tag, out_y, out_nv, out_nx, out_tag,
                           mon_e.y, mon_e.nv, mon_e.nx, mon_e.tag);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(cur_exp);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, got, req);
      end
   endtask

   task automatic add(input logic [31:0] x, input logic [2:0] rm, input logic sgn,
                      input logic [31:0] y, input logic nv, input logic nx);
      vec_t v;
      v.x = x; v.rm = rm; v.sgn = sgn; v.y = y; v.nv = nv; v.nx = nx;
      tv.push_back(v);
   endtask

   task automatic set_in(input logic [31:0] x, input logic [2:0] rm, input logic sgn,
                         input logic [TAG_W-1:0] tag, input logic [31:0] y,
                         input logic nv, input logic nx);
      in_valid = 1'b1; in_x = x; in_rm = rm; in_sgn = sgn; in_tag = tag;
      cur_exp.y = y; cur_exp.tag = tag; cur_exp.nv = nv & FL; cur_exp.nx = nx & FL;
   endtask

   task automatic send(input logic [31:0] x, input logic [2:0] rm, input logic sgn,
                       input logic [TAG_W-1:0] tag, input logic [31:0] y,
                       input logic nv, input logic nx);
      bit ok = 1'b0;
      int t = 0;
      set_in(x, rm, sgn, tag, y, nv, nx);
      while (!ok && t < 60) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 60) begin
         @(posedge clk);
         #2;
         t++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
   endtask

   localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

   initial begin
      logic [31:0] bp_x [4];
      int nxt, seen, first_c, last_c;
      bit acc_now;

      // x, rm, sgn, expected y, nv, nx
      add(32'h40600000, RNE, 1, 32'h00000004, 0, 1);
      add(32'h40600000, RTZ, 1, 32'h00000003, 0, 1);
      add(32'h40600000, RDN, 1, 32'h00000003, 0, 1);
      add(32'h40600000, RUP, 1, 32'h00000004, 0, 1);
      add(32'h40600000, RMM, 1, 32'h00000004, 0, 1);
      add(32'h40600000, 3'd7, 1, 32'h00000003, 0, 1);
      add(32'hC0200000, RNE, 1, 32'hFFFFFFFE, 0, 1);
      add(32'hC0200000, RDN, 1, 32'hFFFFFFFD, 0, 1);
      add(32'hC0200000, RMM, 1, 32'hFFFFFFFD, 0, 1);
      add(32'hC0200000, RTZ, 1, 32'hFFFFFFFE, 0, 1);
      add(32'hC0200000, RUP, 1, 32'hFFFFFFFE, 0, 1);
      add(32'h3F000000, RNE, 1, 32'h00000000, 0, 1);
      add(32'h3F000000, RUP, 1, 32'h00000001, 0, 1);
      add(32'h00000001, RUP, 1, 32'h00000001, 0, 1);
      add(32'h80000000, RDN, 1, 32'h00000000, 0, 0);
      add(32'h80000000, RUP, 0, 32'h00000000, 0, 0);
      add(32'h00000000, RUP, 1, 32'h00000000, 0, 0);
      add(32'h4F000000, RNE, 1, 32'h7FFFFFFF, 1, 0);
      add(32'h4F000000, RNE, 0, 32'h80000000, 0, 0);
      add(32'h7FC00000, RNE, 1, 32'h7FFFFFFF, 1, 0);
      add(32'h7FC00000, RNE, 0, 32'hFFFFFFFF, 1, 0);
      add(32'hFFC00000, RNE, 1, 32'h7FFFFFFF, 1, 0);
      add(32'hBF800000, RNE, 0, 32'h00000000, 1, 0);
      add(32'hFF800000, RNE, 1, 32'h80000000, 1, 0);
      add(32'h7F800000, RNE, 0, 32'hFFFFFFFF, 1, 0);
      add(32'hCF000000, RTZ, 1, 32'h80000000, 0, 0);
      add(32'hCF000001, RTZ, 1, 32'h80000000, 1, 0);
      add(32'hBF000000, RNE, 0, 32'h00000000, 0, 1);
      add(32'hBF400000, RNE, 0, 32'h00000000, 1, 0);
      add(32'h4F800000, RNE, 0, 32'hFFFFFFFF, 1, 0);
      add(32'h5F800000, RNE, 1, 32'h7FFFFFFF, 1, 0);
      add(32'h4F7FFFFF, RNE, 0, 32'hFFFFFF00, 0, 0);
      add(32'h4EFFFFFF, RNE, 1, 32'h7FFFFF80, 0, 0);
      add(32'h3FC00000, RNE, 1, 32'h00000002, 0, 1);
      add(32'h40200000, RNE, 1, 32'h00000002, 0, 1);
      add(32'h3FFFFFFF, RTZ, 1, 32'h00000001, 0, 1);
      add(32'h3FFFFFFF, RNE, 1, 32'h00000002, 0, 1);
      add(32'h3E800000, RUP, 1, 32'h00000001, 0, 1);
      add(32'hBE800000, RDN, 1, 32'hFFFFFFFF, 0, 1);

      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_rm = '0; in_sgn = 1'b0;
      in_tag = '0; out_ready = 1'b1;
      cur_exp.y = '0; cur_exp.tag = '0; cur_exp.nv = 1'b0; cur_exp.nx = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_y",     64'(out_y),     64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
      chk("rst_out_nv",    64'(out_nv),    64'd0);
      chk("rst_out_nx",    64'(out_nx),    64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Inputs with in_valid low must be ignored (monitor flags any output).
      for (int i = 0; i < 4; i++) begin
         in_x = $urandom; in_tag = TAG_W'($urandom);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Pass 1: full throughput; pass 2: random back-pressure.
      for (int i = 0; i < tv.size(); i++)
         send(tv[i].x, tv[i].rm, tv[i].sgn, TAG_W'(i), tv[i].y, tv[i].nv, tv[i].nx);
      drain();
      rand_bp = 1'b1;
      for (int i = 0; i < tv.size(); i++)
         send(tv[i].x, tv[i].rm, tv[i].sgn, TAG_W'(i + 3), tv[i].y, tv[i].nv, tv[i].nx);
      rand_bp = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();

      // Stall: out_ready low for 5 cycles while 4 operands are offered.
      bp_x[0] = 32'h3F800000; bp_x[1] = 32'h40000000;
      bp_x[2] = 32'h40400000; bp_x[3] = 32'h40800000;
      out_ready = 1'b0; nxt = 0; seen = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 30 && (nxt < 4 || seen < 4); c++) begin
         if (nxt < 4) set_in(bp_x[nxt], RNE, 1'b1, TAG_W'(nxt + 1), 32'(nxt + 1), 1'b0, 1'b0);
         else in_valid = 1'b0;
         if (c == 5) out_ready = 1'b1;
         @(negedge clk);
         acc_now = in_valid && in_ready;
         if (out_valid && out_ready) begin
            seen++;
            if (seen == 1) first_c = c;
            last_c = c;
         end
         if (c == 2 || c == 4) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_y",     64'(out_y),     64'd1);
            chk("stall_out_tag",   64'(out_tag),   64'd1);
         end
         if (c == 4) begin
            chk("stall_accepted", 64'(nxt + int'(acc_now)), 64'd2);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
         end
         @(posedge clk); #1;
         if (acc_now) nxt++;
      end
      in_valid = 1'b0;
      chk("stall_outputs", 64'(seen), 64'd4);
      chk("stall_no_gap",  64'(last_c - first_c), 64'd3);
      drain();

      // Reset with two operands in flight.
      out_ready = 1'b0;
      send(32'h3F800000, RNE, 1'b1, 5'd7, 32'd1, 1'b0, 1'b0);
      send(32'h40000000, RNE, 1'b1, 5'd8, 32'd2, 1'b0, 1'b0);
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready",  64'(in_ready),  64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_stale", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;
      send(32'h40600000, RTZ, 1'b1, 5'd9, 32'd3, 1'b0, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
